// File: rtl/disp_pkg.sv
// Shared display types and constants for the BCD counter / digit-scan slice.
package disp_pkg;

  localparam int DIG_W   = 4;
  localparam int BCD_W   = 4;
  localparam int NDIGITS = 4;

  localparam logic [DIG_W-1:0] DIG_RESET = 4'b1110;
  localparam logic [BCD_W-1:0] BCD_MAX   = 4'd9;

  typedef logic [BCD_W-1:0]     bcd_t;
  typedef bcd_t [NDIGITS-1:0]   bcd4_t;

  // Any nibble above 9 is forced to 9 so a stored digit is always legal BCD.
  function automatic bcd_t clamp_bcd(input bcd_t v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell: holds a single BCD digit, steps up/down when enabled by the
// carry/borrow coming in from the less significant cell.
module bcd_digit
  import disp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic ld,
  input  bcd_t ld_val,
  input  logic step,
  input  logic up,
  input  logic cin,
  output bcd_t q,
  output logic cout
);

  // Digit register: clear beats load beats step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= clamp_bcd(ld_val);
    end else if (step && cin) begin
      if (up) begin
        q <= (q == BCD_MAX) ? '0 : q + bcd_t'(1);
      end else begin
        q <= (q == '0) ? BCD_MAX : q - bcd_t'(1);
      end
    end
  end

  // Carry/borrow ripples combinationally; the step qualifier is applied per cell,
  // so cout only means "this cell would roll over if stepped".
  assign cout = cin & (up ? (q == BCD_MAX) : (q == '0));

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with a time-multiplexed digit scan feeding a
// single 7-seg decoder. Count and scan rates come from free-running prescalers.
module bcd_scan_counter
  import disp_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     up,
  input  logic                     clear,
  input  logic                     load,
  input  logic [NDIGITS*BCD_W-1:0] load_val,
  output logic [NDIGITS*BCD_W-1:0] bcd_out,
  output logic [BCD_W-1:0]         digit_val,
  output logic [DIG_W-1:0]         dig,
  output logic                     wrap
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [SW-1:0]    scan_cnt;
  logic             scan_tc;
  logic [1:0]       idx;
  bcd4_t            count;
  bcd4_t            lv;
  logic [NDIGITS:0] carry;
  logic             step;

  assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
  assign scan_tc = (scan_cnt == SW'(SCAN_DIV - 1));
  assign step    = tick & en;
  assign lv      = bcd4_t'(load_val);
  assign carry[0] = 1'b1;

  // Count-rate prescaler; free-running, untouched by clear/load/en.
  always_ff @(posedge clk) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
  end

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clear),
      .ld     (load),
      .ld_val (lv[i]),
      .step   (step),
      .up     (up),
      .cin    (carry[i]),
      .q      (count[i]),
      .cout   (carry[i+1])
    );
  end

  assign bcd_out = count;

  // Wrap pulses only when a step actually happens and the whole chain rolls over.
  always_ff @(posedge clk) begin
    if (!rst_n) wrap <= 1'b0;
    else        wrap <= step & ~clear & ~load & carry[NDIGITS];
  end

  // Scan-slot prescaler and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else begin
      scan_cnt <= scan_tc ? '0 : scan_cnt + SW'(1);
      if (scan_tc) idx <= idx + 2'd1;
    end
  end

  // Select and value registered together so the decoder never sees them skewed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig       <= DIG_RESET;
      digit_val <= '0;
    end else begin
      dig       <= ~(4'b0001 << idx);
      digit_val <= count[idx];
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with small prescalers.
module tb_bcd_scan_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        up;
  logic        clear;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] bcd_out;
  logic [3:0]  digit_val;
  logic [3:0]  dig;
  logic        wrap;

  int errors = 0;
  int checks = 0;
  int tcnt   = 0;
  bit mon_en = 1'b0;

  bcd_scan_counter #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .clear     (clear),
    .load      (load),
    .load_val  (load_val),
    .bcd_out   (bcd_out),
    .digit_val (digit_val),
    .dig       (dig),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lv;
    logic [15:0] exp;
  } ld_vec_t;

  typedef struct {
    logic [15:0] start;
    logic        up;
    logic [15:0] exp;
    logic        exp_wrap;
  } st_vec_t;

  ld_vec_t lvec[5];
  st_vec_t svec[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock edge; the bench tracks where the tick prescaler is.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) tcnt = 0;
    else        tcnt = (tcnt == 3) ? 0 : tcnt + 1;
    #1;
  endtask

  // Advance until the current cycle is a tick cycle.
  task automatic wait_tick();
    int n = 0;
    while (tcnt != 3 && n < 8) begin
      cyc();
      n++;
    end
    if (tcnt != 3) begin
      errors++;
      checks++;
      $display("FAIL wait_tick: timeout got %0d expected 3", tcnt);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_val = v;
    cyc();
    load = 1'b0;
  endtask

  // Exactly one digit select low on every cycle after reset.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("dig_onehot", 16'($countones(~dig)), 16'd1);
    end
  end

  initial begin
    logic [3:0]  dig_s[16];
    logic [3:0]  val_s[16];
    logic [15:0] pat;
    int          run;
    int          p;
    int          pp;
    int          n;

    lvec[0] = '{16'hAF37, 16'h9937};
    lvec[1] = '{16'h1234, 16'h1234};
    lvec[2] = '{16'hFFFF, 16'h9999};
    lvec[3] = '{16'h0A0B, 16'h0909};
    lvec[4] = '{16'h0000, 16'h0000};

    svec[0] = '{16'h9998, 1'b1, 16'h9999, 1'b0};
    svec[1] = '{16'h9999, 1'b1, 16'h0000, 1'b1};
    svec[2] = '{16'h1000, 1'b0, 16'h0999, 1'b0};
    svec[3] = '{16'h0000, 1'b0, 16'h9999, 1'b1};
    svec[4] = '{16'h0199, 1'b1, 16'h0200, 1'b0};
    svec[5] = '{16'h0573, 1'b0, 16'h0572, 1'b0};
    svec[6] = '{16'h0909, 1'b1, 16'h0910, 1'b0};
    svec[7] = '{16'h0010, 1'b0, 16'h0009, 1'b0};

    rst_n = 1'b0; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
    cyc();
    cyc();
    chk("rst_bcd", bcd_out, 16'h0000);
    chk("rst_dig", 16'(dig), 16'h000E);
    chk("rst_val", 16'(digit_val), 16'h0000);
    chk("rst_wrap", 16'(wrap), 16'h0000);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Load/clamp table.
    foreach (lvec[i]) begin
      do_load(lvec[i].lv);
      chk($sformatf("load[%0d]", i), bcd_out, lvec[i].exp);
      chk($sformatf("load_wrap[%0d]", i), 16'(wrap), 16'h0000);
    end

    // Single-step table.
    foreach (svec[i]) begin
      en = 1'b0;
      do_load(svec[i].start);
      en = 1'b1;
      up = svec[i].up;
      wait_tick();
      cyc();
      en = 1'b0;
      chk($sformatf("step[%0d]", i), bcd_out, svec[i].exp);
      chk($sformatf("step_wrap[%0d]", i), 16'(wrap), 16'(svec[i].exp_wrap));
      cyc();
      chk($sformatf("step_hold[%0d]", i), bcd_out, svec[i].exp);
      chk($sformatf("wrap_pulse[%0d]", i), 16'(wrap), 16'h0000);
    end

    // Up rollover across two consecutive ticks.
    do_load(16'h9998);
    en = 1'b1; up = 1'b1;
    wait_tick();
    cyc();
    chk("roll_9999", bcd_out, 16'h9999);
    chk("roll_wrap0", 16'(wrap), 16'h0000);
    cyc();
    wait_tick();
    cyc();
    en = 1'b0;
    chk("roll_0000", bcd_out, 16'h0000);
    chk("roll_wrap1", 16'(wrap), 16'h0001);
    cyc();
    chk("roll_wrap_drop", 16'(wrap), 16'h0000);

    // Clear and load together: clear wins.
    clear = 1'b1; load = 1'b1; load_val = 16'h5555;
    cyc();
    clear = 1'b0; load = 1'b0;
    chk("clr_over_load", bcd_out, 16'h0000);

    // Load on a tick cycle: loaded value, no step.
    en = 1'b1; up = 1'b1;
    wait_tick();
    load = 1'b1; load_val = 16'h0042;
    cyc();
    load = 1'b0; en = 1'b0;
    chk("load_on_tick", bcd_out, 16'h0042);
    chk("load_on_tick_wrap", 16'(wrap), 16'h0000);

    // Clear on a tick cycle at 9999 counting up: no step, no wrap.
    do_load(16'h9999);
    en = 1'b1; up = 1'b1;
    wait_tick();
    clear = 1'b1;
    cyc();
    clear = 1'b0; en = 1'b0;
    chk("clr_on_tick", bcd_out, 16'h0000);
    chk("clr_on_tick_wrap", 16'(wrap), 16'h0000);

    // en low through a tick: hold, no wrap.
    do_load(16'h9999);
    en = 1'b0; up = 1'b1;
    wait_tick();
    cyc();
    chk("en0_hold", bcd_out, 16'h9999);
    chk("en0_wrap", 16'(wrap), 16'h0000);

    // Scan with 1234 held.
    do_load(16'h1234);
    cyc();
    cyc();
    for (int i = 0; i < 16; i++) begin
      dig_s[i] = dig;
      val_s[i] = digit_val;
      cyc();
    end
    pat = 16'h1234;
    run = 0;
    pp  = -1;
    n   = 0;
    for (int i = 0; i < 16; i++) begin
      p = -1;
      for (int b = 0; b < 4; b++) if (!dig_s[i][b]) p = b;
      if (p >= 0) begin
        chk($sformatf("scan_val[%0d]", i), 16'(val_s[i]), 16'((pat >> (4 * p)) & 16'h000F));
      end
      if (pp >= 0 && p != pp) begin
        if (n > 0) chk($sformatf("scan_slot[%0d]", i), 16'(run), 16'd2);
        chk($sformatf("scan_order[%0d]", i), 16'(p), 16'((pp + 1) % 4));
        n++;
        run = 0;
      end
      run++;
      pp = p;
    end
    chk("scan_changes", 16'(n >= 6), 16'd1);

    // Reset in mid-operation while digit 2 is being scanned.
    do_load(16'h0573);
    chk("pre_rst_count", bcd_out, 16'h0573);
    n = 0;
    while (dig != 4'b1011 && n < 12) begin
      cyc();
      n++;
    end
    chk("pre_rst_dig", 16'(dig), 16'h000B);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_bcd", bcd_out, 16'h0000);
    chk("mid_rst_dig", 16'(dig), 16'h000E);
    chk("mid_rst_val", 16'(digit_val), 16'h0000);
    chk("mid_rst_wrap", 16'(wrap), 16'h0000);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_bcd", bcd_out, 16'h0000);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
